// File: rtl/rd_addr_seq.sv
// Read-address sequencer: issues len consecutive 8-bit addresses from base
// under a valid/ready handshake, with abort and a one-cycle done pulse.
module rd_addr_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] base,
  input  logic [7:0] len,
  output logic [7:0] addr,
  output logic       addr_vld,
  input  logic       addr_rdy,
  output logic [7:0] cnt,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] len_q;
  logic [7:0] len_m1;
  logic       xfer;
  logic       last;

  function automatic logic [7:0] inc8(input logic [7:0] v);
    return v + 8'd1;
  endfunction

  // len=0 encodes 256, so len-1 wrapping to 255 gives the right last index
  assign len_m1 = len_q - 8'd1;
  assign xfer   = (state == RUN) && addr_rdy && !abort;
  assign last   = (cnt == len_m1);

  assign addr_vld = (state == RUN);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr  <= 8'd0;
      cnt   <= 8'd0;
      len_q <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr  <= base;
            len_q <= len;
            cnt   <= 8'd0;
            state <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (xfer) begin
            addr <= inc8(addr);
            cnt  <= inc8(cnt);
            if (last) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rd_addr_seq.sv
// Scoreboard bench for rd_addr_seq: expected transfers and done snapshots are
// queued by the stimulus and consumed by a negedge monitor.
module tb_rd_addr_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] base = 8'd0;
  logic [7:0] len = 8'd0;
  logic [7:0] addr;
  logic       addr_vld;
  logic       addr_rdy = 1'b0;
  logic [7:0] cnt;
  logic       busy;
  logic       done;

  rd_addr_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base(base), .len(len), .addr(addr), .addr_vld(addr_vld),
    .addr_rdy(addr_rdy), .cnt(cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] a; logic [7:0] c; } done_t;

  logic [7:0] exp_q[$];
  done_t      done_q[$];
  int ncmp = 0;
  int nfail = 0;
  int done_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (addr_vld && addr_rdy && !abort) begin
        if (exp_q.size() == 0) chk("xfer_unexpected", addr, -1);
        else chk("xfer_addr", addr, exp_q.pop_front());
      end
      if (done) begin
        done_seen++;
        if (done_q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          done_t d;
          d = done_q.pop_front();
          chk("done_addr", addr, d.a);
          chk("done_cnt", cnt, d.c);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [7:0] b, input logic [7:0] l);
    base  = b;
    len   = l;
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int maxc);
    int prev;
    bit seen;
    prev = done_seen;
    seen = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      #1;
      if (done_seen != prev) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk({name, "_timeout"}, 0, 1);
    cycle();
    chk({name, "_idle_busy"}, busy, 0);
    chk({name, "_idle_done"}, done, 0);
    chk({name, "_idle_vld"}, addr_vld, 0);
  endtask

  initial begin
    done_t d;
    logic [7:0] bp_pat[5];
    logic [7:0] bp_adr[5];
    bp_pat = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd1};
    bp_adr = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h02};

    // Reset state, including with clock running and start asserted
    start = 1'b1;
    #12;
    chk("rst_addr", addr, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_vld", addr_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Basic run
    addr_rdy = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h10 + 8'(i));
    d.a = 8'h14; d.c = 8'd4; done_q.push_back(d);
    kick(8'h10, 8'd4);
    chk("basic_first_vld", addr_vld, 1);
    chk("basic_first_addr", addr, 8'h10);
    wait_done("basic", 10);
    cycle();
    chk("idle_hold_addr", addr, 8'h14);
    chk("idle_hold_cnt", cnt, 4);

    // Backpressure
    for (int i = 0; i < 3; i++) exp_q.push_back(8'(i));
    d.a = 8'h03; d.c = 8'd3; done_q.push_back(d);
    kick(8'h00, 8'd3);
    for (int i = 0; i < 5; i++) begin
      addr_rdy = bp_pat[i][0];
      @(negedge clk);
      chk("bp_addr", addr, bp_adr[i]);
      chk("bp_vld", addr_vld, 1);
      cycle();
    end
    addr_rdy = 1'b1;
    chk("bp_done", done, 1);
    wait_done("bp", 3);

    // Abort, with start ignored while busy
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h21);
    kick(8'h20, 8'd8);
    start = 1'b1;
    base  = 8'h99;
    len   = 8'd2;
    cycle();
    start = 1'b0;
    chk("busy_start_ign", addr, 8'h21);
    cycle();
    chk("abort_pre_addr", addr, 8'h22);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_addr", addr, 8'h22);
    chk("abort_cnt", cnt, 2);
    cycle();
    chk("abort_stay_idle", busy, 0);

    // len=1 at 0xFF
    exp_q.push_back(8'hFF);
    d.a = 8'h00; d.c = 8'd1; done_q.push_back(d);
    kick(8'hFF, 8'd1);
    wait_done("len1", 4);

    // len=0 means 256 transfers with address wrap
    for (int i = 0; i < 256; i++) exp_q.push_back(8'hFE + 8'(i));
    d.a = 8'hFE; d.c = 8'd0; done_q.push_back(d);
    kick(8'hFE, 8'd0);
    wait_done("wrap", 300);

    // Asynchronous reset mid-sequence
    for (int i = 0; i < 3; i++) exp_q.push_back(8'h40 + 8'(i));
    kick(8'h40, 8'd10);
    cycle();
    cycle();
    cycle();
    chk("ar_pre_addr", addr, 8'h43);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_vld", addr_vld, 0);
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_addr", addr, 0);
    chk("ar_cnt", cnt, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (4) cycle();
    chk("ar_after_busy", busy, 0);
    // First start after release is accepted
    exp_q.push_back(8'h05);
    d.a = 8'h06; d.c = 8'd1; done_q.push_back(d);
    kick(8'h05, 8'd1);
    chk("ar_restart_vld", addr_vld, 1);
    wait_done("ar_restart", 4);

    cycle();
    chk("done_count", done_seen, 5);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/rd_addr_seq.md
RD_ADDR_SEQ -- requirements
Module: rd_addr_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 8 bits.
REQ-002 clk  input  1  single clock for the block; all state is updated on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 start  input  1  request to begin a sequence; sampled only in IDLE.
REQ-005 abort  input  1  synchronous cancel of the running sequence.
REQ-006 base  input  8  first address of the sequence; captured on accepted start.
REQ-007 len  input  8  number of addresses to issue; 1..255 literal, 0 means 256; captured on accepted start.
REQ-008 addr  output  8  current address.
REQ-009 addr_vld  output  1  addr is valid and offered downstream.
REQ-010 addr_rdy  input  1  downstream accepts addr this cycle.
REQ-011 cnt  output  8  number of addresses already transferred in the current sequence, modulo 256.
REQ-012 busy  output  1  high in RUN and DONE.
REQ-013 done  output  1  one-cycle pulse after the last transfer.

Function
REQ-014 The block SHALL implement three states, IDLE, RUN and DONE, encoded in a registered state variable.
REQ-015 IDLE with start=1: capture base into addr and len into an internal register, clear cnt to 0, and go to RUN on the next edge.
REQ-016 IDLE with start=0: hold state; addr and cnt keep their last values.
REQ-017 In RUN, addr_vld SHALL be 1; it SHALL be 0 in IDLE and DONE.
REQ-018 A transfer SHALL occur on each edge where addr_vld=1 and addr_rdy=1.
REQ-019 On a transfer, addr SHALL become addr+1 modulo 256 (255 wraps to 0), and cnt SHALL become cnt+1 modulo 256.
REQ-020 While addr_vld=1 and addr_rdy=0, addr and cnt SHALL hold stable.
REQ-021 A transfer SHALL be the last transfer when cnt equals captured len-1, with len=0 treated as cnt=255.
REQ-022 On the last transfer, state SHALL go to DONE; addr and cnt SHALL still advance per REQ-019.
REQ-023 In DONE, done SHALL be 1 for exactly one cycle, and state SHALL then return to IDLE unconditionally.
REQ-024 start SHALL be ignored in RUN and DONE; no request is queued.
REQ-025 abort=1 in RUN SHALL return the block to IDLE on the next edge.
REQ-026 An abort SHALL override a coincident transfer: addr and cnt hold, and done does not pulse.
REQ-027 abort SHALL be ignored in IDLE and DONE; in IDLE with start=1 and abort=1 asserted together, start wins.
REQ-028 Both incrementers (addr, cnt) SHALL be pure combinational 8-bit +1 with carry-out discarded.
REQ-029 The addr/cnt to next-state path SHALL be a single cycle, with no added latency.
REQ-030 All outputs SHALL be driven directly from registers or from the state decode; there SHALL be no combinational path from addr_rdy to addr_vld.
REQ-031 The first address SHALL be offered one cycle after the accepted start; the minimum sequence time is len+2 cycles from start to the end of done.

Reset
REQ-032 While rst_n=0, the block SHALL be held in IDLE with addr=0, cnt=0, addr_vld=0, busy=0 and done=0, independent of clk.
REQ-033 Reset asserted mid-sequence SHALL discard the sequence without a done pulse; after release the block waits for a new start.
REQ-034 Deassertion of rst_n SHALL take effect only at clk edges; the first accepted start SHALL be on the first edge with rst_n=1.

Verification
REQ-035 Basic run: base=0x10, len=4, addr_rdy=1 -> addr 0x10,0x11,0x12,0x13 on consecutive cycles; done one cycle after 0x13; cnt=4; return to IDLE.
REQ-036 Wrap with len=0: base=0xFE, len=0, addr_rdy=1 -> 256 transfers 0xFE,0xFF,0x00,...,0xFD; done once; final addr=0xFE, cnt=0.
REQ-037 Backpressure: base=0x00, len=3, addr_rdy pattern 1,0,0,1,1 -> addr sequence 0x00,0x01,0x01,0x01,0x02 with vld=1 throughout; done after the fifth cycle.
REQ-038 Abort: base=0x20, len=8, abort pulsed with addr_rdy=1 while addr=0x22 -> next cycle IDLE, addr=0x22, cnt=2, no done; start ignored while busy.
REQ-039 len=1: base=0xFF -> single transfer at 0xFF; done next cycle; addr wraps to 0x00, cnt=1.
REQ-040 Async reset: assert rst_n=0 between edges in RUN -> addr_vld, busy and done drop immediately; addr=0, cnt=0; no done pulse after release.
